if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage feeding the decode stage. Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and presents a registered instruction/PC pair (`IR`, `PC`) to decode. Honours decode's `IsStall`/`IsFlush` controls, redirects to `BrTarget` on flush, and stops fetching after a `HALT`.

## Interface
- `RESET_PC`, default 0: word address fetched first after reset (width `WIDTH`-2).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `IsStall` input 1: decode is not accepting; hold `IR`/`PC`.
- `IsFlush` input 1: discard the current and in-flight instruction; redirect to `BrTarget`.
- `BrTarget` input `WIDTH`-2: redirect word address, sampled only when `IsFlush`=1.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output `WIDTH`-2: word address; equals the internal `fetch_pc`.
- `imem_ack` input 1: one-cycle pulse; `imem_rdata` is valid this cycle.
- `imem_rdata` input `WIDTH`: fetched instruction.
- `IR` output `WIDTH`: instruction to decode.
- `PC` output `WIDTH`-2: word address of `IR`.
- `Halted` output 1: stage stopped on `HALT`.

## Operation
- States: FETCH, HOLD, DROP, HALTED. Reset enters FETCH with `fetch_pc`=`RESET_PC`.
- Handshake:
  - `imem_req` is 1 in FETCH and DROP, and 0 in HOLD and HALTED.
  - `imem_addr` is stable while `imem_req`=1 until ack.
  - `imem_ack` may arrive in the same cycle `imem_req` rises (zero-wait memory).
- FETCH, ack, no stall, no flush:
  - `IR`←`imem_rdata`, `PC`←`fetch_pc`, `fetch_pc`←`fetch_pc`+1.
  - If `imem_rdata[31:26]`==`HALT`, go to HALTED. The `HALT` itself is still delivered to decode.
- FETCH, ack, `IsStall`=1: capture rdata and `fetch_pc` in the hold buffer, increment `fetch_pc`, go to HOLD. `IR`/`PC` unchanged.
- FETCH, no ack:
  - If `IsStall`=0: `IR`←`NOP`, `PC` unchanged. This is a bubble; decode never sees a duplicate instruction.
  - If `IsStall`=1: `IR`/`PC` unchanged.
- HOLD, `IsStall` falls: `IR`/`PC`←hold buffer. Go to HALTED if the buffered opcode is `HALT`, else FETCH.
- Flush:
  - `IsFlush` overrides `IsStall`.
  - Every state does `IR`←`NOP` and `fetch_pc`←`BrTarget`, and discards the hold buffer.
  - FETCH with request pending and no ack this cycle: go to DROP. The target is latched into `fetch_pc` at flush; until the stale ack, `imem_addr` shows the pending old address from a separate `req_addr` register.
  - FETCH with ack in the same cycle: data is discarded; go to FETCH at the target.
  - HOLD or HALTED: go to FETCH at the target. This also clears `Halted`.
- DROP: wait for ack, discard the data, go to FETCH. A second flush in DROP updates the target only.
- `fetch_pc` increments modulo 2^(`WIDTH`-2); 0x3FFFFFFF+1 = 0.
- `Halted`=1 exactly when state is HALTED.

## Timing
- Reset values: `IR`=`NOP`, `PC`=0, `imem_req`=0, `Halted`=0, `fetch_pc`=`RESET_PC`.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- `IR`/`PC` are registered. An instruction acked in cycle n is visible to decode in cycle n+1.
- With zero-wait memory and no stall, throughput is one instruction per cycle.
- After a flush in cycle n, the first `imem_req` at `BrTarget` is in cycle n+1 from FETCH, HOLD or HALTED, or in the cycle after the stale ack from DROP.
- Reset mid-operation immediately returns all registers to their reset values. The memory must drop a pending ack on reset.

## Structure
- From the shared params/ISA headers: `WIDTH`, `NOP`, `HALT`, and the opcode field slice [31:26].
- State encoding: local constants. Not shared.
- One natural sub-module, `if_hold_buf`: a one-entry instruction/PC register with load, clear and valid.

## Test plan
- Reset with `RESET_PC`=0x10 and zero-wait memory returning addr+0x1000 → `imem_addr` is 0x10, 0x11, 0x12… on consecutive cycles; `IR` goes `NOP`, then 0x1010, 0x1011… one cycle behind; `PC` tracks.
- Memory with 2 wait cycles → `IR`=`NOP` bubbles between instructions; each instruction appears exactly once.
- `IsStall` high for 3 cycles while an ack lands → `IR`/`PC` frozen; `imem_req`=0 in HOLD. On release, the buffered instruction appears and fetch resumes at the next address with no loss or duplication.
- `IsFlush` with `BrTarget`=0x200 while a request to 0x05 is pending → stale ack data discarded; `IR`=`NOP`; next request is 0x200; `PC`=0x200 with the first new instruction.
- `HALT` fetched at 0x07 → `IR`=`HALT`, `PC`=0x07, `Halted`=1, `imem_req`=0 thereafter. Then `IsFlush` with `BrTarget`=0x40 → `Halted`=0, fetch restarts at 0x40.
- `fetch_pc` at 0x3FFFFFFF → next request to 0x0. Also: `IsStall` and `IsFlush` together → flush behaviour wins.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared ISA constants and helpers for the fetch stage
package if_stage_pkg;
    localparam int WIDTH  = 32;
    localparam int AW     = WIDTH - 2;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [WIDTH-1:0]         NOP  = 32'h0000_0000;
    localparam logic [OPC_HI-OPC_LO:0]   HALT = 6'h3F;

    function automatic logic is_halt(input logic [WIDTH-1:0] instr);
        return instr[OPC_HI:OPC_LO] == HALT;
    endfunction
endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - one-entry instruction/PC buffer used while decode stalls
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] ir_i,
    input  logic [AW-1:0]    pc_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ir_o,
    output logic [AW-1:0]    pc_o
);
    logic             valid_q;
    logic [WIDTH-1:0] ir_q;
    logic [AW-1:0]    pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ir_q    <= NOP;
            pc_q    <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ir_q    <= ir_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: owns fetch PC, drives imem req/ack,
// presents registered IR/PC to decode with stall, flush and halt handling.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IsStall,
    input  logic             IsFlush,
    input  logic [AW-1:0]    BrTarget,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] IR,
    output logic [AW-1:0]    PC,
    output logic             Halted
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DROP   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]    req_addr_q, req_addr_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             run_q;

    logic             hb_load, hb_clr, hb_valid;
    logic [WIDTH-1:0] hb_ir;
    logic [AW-1:0]    hb_pc;
    logic             ack;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hb_load),
        .clr_i   (hb_clr),
        .ir_i    (imem_rdata),
        .pc_i    (fetch_pc_q),
        .valid_o (hb_valid),
        .ir_o    (hb_ir),
        .pc_o    (hb_pc)
    );

    // run_q keeps the request low while in reset and for the reset cycle itself
    assign imem_req  = run_q && (state_q == S_FETCH || state_q == S_DROP);
    assign imem_addr = (state_q == S_DROP) ? req_addr_q : fetch_pc_q;
    assign ack       = imem_req && imem_ack;
    assign IR        = ir_q;
    assign PC        = pc_q;
    assign Halted    = (state_q == S_HALTED);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        hb_load    = 1'b0;
        hb_clr     = 1'b0;

        if (IsFlush) begin
            ir_d       = NOP;
            fetch_pc_d = BrTarget;
            hb_clr     = 1'b1;
        end

        case (state_q)
            S_FETCH: begin
                if (IsFlush) begin
                    // an unacked request must have its stale ack absorbed in DROP
                    if (imem_req && !imem_ack) begin
                        state_d    = S_DROP;
                        req_addr_d = fetch_pc_q;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    if (IsStall) begin
                        hb_load = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        ir_d = imem_rdata;
                        pc_d = fetch_pc_q;
                        if (is_halt(imem_rdata)) state_d = S_HALTED;
                    end
                end else if (!IsStall) begin
                    ir_d = NOP;
                end
            end
            S_HOLD: begin
                if (IsFlush) begin
                    state_d = S_FETCH;
                end else if (!IsStall && hb_valid) begin
                    ir_d    = hb_ir;
                    pc_d    = hb_pc;
                    hb_clr  = 1'b1;
                    state_d = is_halt(hb_ir) ? S_HALTED : S_FETCH;
                end
            end
            S_DROP: begin
                if (ack) state_d = S_FETCH;
            end
            S_HALTED: begin
                if (IsFlush) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            ir_q       <= NOP;
            pc_q       <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            run_q      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
    import if_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             IsStall, IsFlush;
    logic [AW-1:0]    BrTarget;
    logic             imem_req, imem_ack;
    logic [AW-1:0]    imem_addr;
    logic [WIDTH-1:0] imem_rdata, IR;
    logic [AW-1:0]    PC;
    logic             Halted;

    int               waits;
    int               cnt;
    int               n_pass = 0;
    int               n_total = 0;

    localparam logic [AW-1:0]    HALT_ADDR = 30'h07;
    localparam logic [WIDTH-1:0] HALT_WORD = 32'hFC00_0000;

    if_stage #(.RESET_PC(30'h10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IsStall    (IsStall),
        .IsFlush    (IsFlush),
        .BrTarget   (BrTarget),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .IR         (IR),
        .PC         (PC),
        .Halted     (Halted)
    );

    always #5 clk = ~clk;

    // memory: acks after `waits` cycles of continuous request, drops pending ack on reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else                           cnt <= 0;
    end
    assign imem_ack   = imem_req && (cnt == waits);
    assign imem_rdata = (imem_addr == HALT_ADDR) ? HALT_WORD : ({2'b00, imem_addr} + 32'h1000);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] ir_e, input logic [AW-1:0] pc_e,
                           input logic req_e, input logic [AW-1:0] addr_e);
        chk({tag, ".IR"}, 64'(IR), 64'(ir_e));
        chk({tag, ".PC"}, 64'(PC), 64'(pc_e));
        chk({tag, ".req"}, 64'(imem_req), 64'(req_e));
        if (req_e) chk({tag, ".addr"}, 64'(imem_addr), 64'(addr_e));
    endtask

    initial begin
        rst_n = 1'b0; IsStall = 1'b0; IsFlush = 1'b0; BrTarget = '0; waits = 0;
        @(negedge clk); @(negedge clk);
        chk_out("reset", NOP, 30'h0, 1'b0, 30'h0);
        chk("reset.Halted", 64'(Halted), 64'(0));
        rst_n = 1'b1;

        // zero-wait streaming from RESET_PC
        step(); chk_out("zw0", NOP,          30'h00, 1'b1, 30'h10);
        step(); chk_out("zw1", 32'h0000_1010, 30'h10, 1'b1, 30'h11);
        step(); chk_out("zw2", 32'h0000_1011, 30'h11, 1'b1, 30'h12);
        step(); chk_out("zw3", 32'h0000_1012, 30'h12, 1'b1, 30'h13);

        // two wait cycles: bubbles, each instruction once
        waits = 2;
        step(); chk_out("ws0", NOP,          30'h12, 1'b1, 30'h13);
        step(); chk_out("ws1", NOP,          30'h12, 1'b1, 30'h13);
        step(); chk_out("ws2", 32'h0000_1013, 30'h13, 1'b1, 30'h14);
        step(); chk_out("ws3", NOP,          30'h13, 1'b1, 30'h14);
        step(); chk_out("ws4", NOP,          30'h13, 1'b1, 30'h14);
        step(); chk_out("ws5", 32'h0000_1014, 30'h14, 1'b1, 30'h15);

        // stall for 3 cycles while ack for 0x15 lands
        waits = 0; IsStall = 1'b1;
        step(); chk_out("st0", 32'h0000_1014, 30'h14, 1'b0, 30'h0);
        step(); chk_out("st1", 32'h0000_1014, 30'h14, 1'b0, 30'h0);
        step(); chk_out("st2", 32'h0000_1014, 30'h14, 1'b0, 30'h0);
        IsStall = 1'b0;
        step(); chk_out("st3", 32'h0000_1015, 30'h15, 1'b1, 30'h16);
        step(); chk_out("st4", 32'h0000_1016, 30'h16, 1'b1, 30'h17);

        // flush with ack in the same cycle, then flush while 0x05 is pending
        IsFlush = 1'b1; BrTarget = 30'h05;
        step(); chk_out("fa0", NOP, 30'h16, 1'b1, 30'h05);
        IsFlush = 1'b0; waits = 3;
        step(); chk_out("fp0", NOP, 30'h16, 1'b1, 30'h05);
        IsFlush = 1'b1; BrTarget = 30'h200;
        step(); chk_out("fp1", NOP, 30'h16, 1'b1, 30'h05);
        IsFlush = 1'b0;
        step(); chk_out("fp2", NOP, 30'h16, 1'b1, 30'h05);
        chk("fp2.ack", 64'(imem_ack), 64'(1));
        step(); chk_out("fp3", NOP, 30'h16, 1'b1, 30'h200);
        waits = 0;
        step(); chk_out("fp4", 32'h0000_1200, 30'h200, 1'b1, 30'h201);

        // HALT at 0x07, then restart by flush to 0x40
        IsFlush = 1'b1; BrTarget = 30'h07;
        step(); chk_out("h0", NOP, 30'h200, 1'b1, 30'h07);
        IsFlush = 1'b0;
        step(); chk_out("h1", HALT_WORD, 30'h07, 1'b0, 30'h0);
        chk("h1.Halted", 64'(Halted), 64'(1));
        step(); chk_out("h2", HALT_WORD, 30'h07, 1'b0, 30'h0);
        chk("h2.Halted", 64'(Halted), 64'(1));
        IsFlush = 1'b1; BrTarget = 30'h40;
        step(); chk_out("h3", NOP, 30'h07, 1'b1, 30'h40);
        chk("h3.Halted", 64'(Halted), 64'(0));
        IsFlush = 1'b0;
        step(); chk_out("h4", 32'h0000_1040, 30'h40, 1'b1, 30'h41);

        // fetch_pc wrap
        IsFlush = 1'b1; BrTarget = 30'h3FFF_FFFF;
        step(); chk_out("wr0", NOP, 30'h40, 1'b1, 30'h3FFF_FFFF);
        IsFlush = 1'b0;
        step(); chk_out("wr1", 32'h4000_0FFF, 30'h3FFF_FFFF, 1'b1, 30'h0);

        // stall and flush together: flush wins
        IsStall = 1'b1; IsFlush = 1'b1; BrTarget = 30'h80;
        step(); chk_out("sf0", NOP, 30'h3FFF_FFFF, 1'b1, 30'h80);
        IsStall = 1'b0; IsFlush = 1'b0;
        step(); chk_out("sf1", 32'h0000_1080, 30'h80, 1'b1, 30'h81);

        // asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1 chk_out("ar", NOP, 30'h0, 1'b0, 30'h0);
        chk("ar.Halted", 64'(Halted), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
